spi_cfg_master: RTL and testbench
=================================

SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: iclk cycles per sclk half-period; legal range 1..255.
REQ-002 SHALL have parameter GAP_CYC, default 4: iclk cycles of idle sclk-low gap after each frame; legal range 1..255.
REQ-003 SHALL have port iclk, input, 1: the single clock, sampled on its rising edge.
REQ-004 SHALL have port rstn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1: command offered.
REQ-006 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_rw, input, 1: 1 = read, 0 = write.
REQ-008 SHALL have port cmd_addr, input, 7: register address (0..7 used for ch0..ch7).
REQ-009 SHALL have port cmd_wdata, input, 8: write data.
REQ-010 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 8: data captured from miso.
REQ-012 SHALL have port rsp_err, output, 1: readback mismatch flag (see Configuration).
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-014 SHALL have port sclk, output, 1: serial clock to the target's sclk.
REQ-015 SHALL have port mosi, output, 1: serial data to the target's serial_in.
REQ-016 SHALL have port miso, input, 1: serial data from the target's serial_out.

Function
REQ-017 SHALL implement states IDLE, SHIFT, GAP, RESP (plus VERIFY under the macro); cmd_ready is high only in IDLE.
REQ-018 SHALL, on acceptance at cycle 0, latch {cmd_rw, cmd_addr, cmd_wdata} as a 16-bit frame and enter SHIFT at cycle 1.
REQ-019 SHALL send frame bits MSB first: bit15 = rw, bits14:8 = addr, bits7:0 = wdata (zeros for reads).
REQ-020 SHALL hold sclk low for CLK_DIV cycles and then high for CLK_DIV cycles per bit, giving 16 bits in 32*CLK_DIV cycles.
REQ-021 SHALL update mosi only in the cycle that sclk goes low; mosi is stable while sclk is high.
REQ-022 SHALL sample miso in the iclk cycle in which sclk rises, for bits 7..0 only, shifting MSB first into rsp_rdata.
REQ-023 SHALL hold sclk and mosi low in GAP for GAP_CYC cycles, then enter RESP.
REQ-024 SHALL assert rsp_valid for exactly one cycle in RESP, at cycle 1+32*CLK_DIV+GAP_CYC, and return to IDLE on the next cycle.
REQ-025 SHALL update rsp_rdata on every frame, writes included; the value holds until the next frame completes.
REQ-026 SHALL ignore cmd_valid while busy; no queuing.
REQ-027 SHALL accept a new command in the first IDLE cycle after RESP, giving back-to-back frames separated by at least GAP_CYC+2 sclk-low cycles.
REQ-028 SHALL use an 8-bit half-period counter that wraps to 0 at CLK_DIV-1, and a 5-bit bit counter that terminates at 16.

Reset
REQ-029 SHALL, when rstn is low at a rising edge, set the state to IDLE and clear all state and counters.
REQ-030 SHALL reset outputs as follows: sclk=0, mosi=0, cmd_ready=1 on the first cycle with rstn high, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
REQ-031 SHALL, when reset arrives mid-frame, abort the frame without generating rsp_valid, and drive sclk low on the next edge.

Configuration
REQ-032 SHALL recognise the macro SPI_CFG_MASTER_VERIFY_EN.
REQ-033 With the macro defined, each write SHALL be followed after GAP by an automatic read frame to the same address (the VERIFY state), and rsp_valid SHALL fire only after the second frame's GAP, at cycle 1+2*(32*CLK_DIV+GAP_CYC).
REQ-034 With the macro defined, rsp_rdata SHALL be the readback value, and rsp_err SHALL be (readback != wdata), valid with rsp_valid.
REQ-035 With the macro undefined, there SHALL be no VERIFY state, rsp_err SHALL be tied to 0, and writes SHALL complete after one frame.

Verification
REQ-036 Reset: hold rstn low for 3 cycles with cmd_valid=1 -> sclk=0, mosi=0, rsp_valid=0, busy=0; cmd_ready=1 on the first cycle after release.
REQ-037 Write, CLK_DIV=2, GAP_CYC=4: addr=3, wdata=0xA5 -> mosi bit sequence 0,0000011,10100101, 16 sclk rising edges, rsp_valid pulses at cycle 69 (no macro).
REQ-038 Read: addr=5, with a miso model returning 0x3C -> rsp_rdata=0x3C at rsp_valid, and mosi data bits all 0.
REQ-039 Busy: cmd_valid held high during a frame -> exactly one frame is sent; the second command is accepted at the cycle after RESP.
REQ-040 Reset asserted at cycle 20 of a frame -> no rsp_valid; sclk=0 from the next edge; a new command completes normally afterwards.
REQ-041 With SPI_CFG_MASTER_VERIFY_EN, write 0x5A to addr 2 with a miso model returning 0x5B -> two frames, rsp_rdata=0x5B, rsp_err=1; with a model returning 0x5A -> rsp_err=0.

Source files
------------

// File: rtl/spi_cfg_master.sv
// spi_cfg_master: 16-bit SPI configuration master ({rw, addr[6:0], data[7:0]}, MSB first).
// sclk idles low; mosi changes on the sclk falling edge; miso is sampled as sclk rises.
// Optional macro SPI_CFG_MASTER_VERIFY_EN: each write is followed by an automatic
// readback frame, and rsp_err flags a readback that differs from the written data.
module spi_cfg_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic       iclk,
  input  logic       rstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [7:0] HC_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    GAP,
`ifdef SPI_CFG_MASTER_VERIFY_EN
    VERIFY,
`endif
    RESP
  } state_t;

  state_t      state, nstate;
  logic [15:0] frame;
  logic [7:0]  hc;
  logic        phase;
  logic [4:0]  bitcnt;
  logic [7:0]  gc;
  logic [7:0]  rxsh;
  logic [7:0]  rdata_r;
  logic        sclk_r, mosi_r;
  logic        shifting, hc_wrap, frame_end, gap_end;

`ifdef SPI_CFG_MASTER_VERIFY_EN
  logic       rw_l;
  logic       vphase;
  logic       err_r;
  logic [6:0] addr_l;
  logic [7:0] wdata_l;
  assign shifting = (state == SHIFT) || (state == VERIFY);
  assign rsp_err  = err_r;
`else
  assign shifting = (state == SHIFT);
  assign rsp_err  = 1'b0;
`endif

  assign hc_wrap   = (hc == HC_LAST);
  assign frame_end = shifting && phase && hc_wrap && (bitcnt == 5'd15);
  assign gap_end   = (state == GAP) && (gc == GAP_LAST);

  assign sclk      = sclk_r;
  assign mosi      = mosi_r;
  assign rsp_rdata = rdata_r;

  // State register
  always_ff @(posedge iclk) begin
    if (!rstn) state <= IDLE;
    else       state <= nstate;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    nstate    = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) nstate = SHIFT;
      end
      SHIFT: if (frame_end) nstate = GAP;
`ifdef SPI_CFG_MASTER_VERIFY_EN
      VERIFY: if (frame_end) nstate = GAP;
      GAP: if (gap_end) nstate = rw_l ? RESP : VERIFY;
`else
      GAP: if (gap_end) nstate = RESP;
`endif
      RESP: begin
        rsp_valid = 1'b1;
        nstate    = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Serial datapath: frame shifter, sclk/mosi generation, miso capture, response registers
  always_ff @(posedge iclk) begin
    if (!rstn) begin
      frame   <= '0;
      hc      <= '0;
      phase   <= 1'b0;
      bitcnt  <= '0;
      gc      <= '0;
      rxsh    <= '0;
      rdata_r <= '0;
      sclk_r  <= 1'b0;
      mosi_r  <= 1'b0;
`ifdef SPI_CFG_MASTER_VERIFY_EN
      rw_l    <= 1'b0;
      vphase  <= 1'b0;
      err_r   <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
`endif
    end else if (state == IDLE) begin
      if (cmd_valid) begin
        frame  <= {cmd_rw, cmd_addr, cmd_rw ? 8'h00 : cmd_wdata};
        mosi_r <= cmd_rw;
        sclk_r <= 1'b0;
        hc     <= '0;
        phase  <= 1'b0;
        bitcnt <= '0;
        gc     <= '0;
`ifdef SPI_CFG_MASTER_VERIFY_EN
        rw_l    <= cmd_rw;
        vphase  <= 1'b0;
        addr_l  <= cmd_addr;
        wdata_l <= cmd_wdata;
`endif
      end
    end else if (shifting) begin
      if (hc_wrap) begin
        hc <= '0;
        if (!phase) begin
          sclk_r <= 1'b1;
          phase  <= 1'b1;
          if (bitcnt[3]) rxsh <= {rxsh[6:0], miso};
        end else begin
          sclk_r <= 1'b0;
          phase  <= 1'b0;
          bitcnt <= bitcnt + 5'd1;
          if (bitcnt == 5'd15) begin
            mosi_r <= 1'b0;
            gc     <= '0;
          end else begin
            frame  <= {frame[14:0], 1'b0};
            mosi_r <= frame[14];
          end
        end
      end else begin
        hc <= hc + 8'd1;
      end
    end else if (state == GAP) begin
      if (!gap_end) begin
        gc <= gc + 8'd1;
`ifdef SPI_CFG_MASTER_VERIFY_EN
      end else if (!rw_l) begin
        // Readback frame starts straight from the gap so it lines up with a normal frame start.
        frame  <= {1'b1, addr_l, 8'h00};
        mosi_r <= 1'b1;
        hc     <= '0;
        phase  <= 1'b0;
        bitcnt <= '0;
        rw_l   <= 1'b1;
        vphase <= 1'b1;
      end else begin
        rdata_r <= rxsh;
        err_r   <= vphase && (rxsh != wdata_l);
      end
`else
      end else begin
        rdata_r <= rxsh;
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master with CLK_DIV=2, GAP_CYC=4 and a shift-register miso target model.
module tb_spi_cfg_master;

  localparam int CD = 2;
  localparam int GP = 4;
`ifdef SPI_CFG_MASTER_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam int T1 = 1 + 32*CD + GP;        // single frame response cycle
  localparam int T2 = 1 + 2*(32*CD + GP);    // write + readback response cycle

  logic       iclk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready, rsp_valid, rsp_err, busy, sclk, mosi, miso;
  logic [7:0] rsp_rdata;

  logic [7:0] resp_val = '0;
  int         rise_cnt = 0;
  int         rise_base = 0;
  int         mk;

  int n_cmp = 0;
  int n_bad = 0;

  spi_cfg_master #(.CLK_DIV(CD), .GAP_CYC(GP)) dut (
    .iclk(iclk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 iclk = ~iclk;

  // Target model: counts sclk rises, presents resp_val MSB first during data bits 7..0
  always @(posedge sclk) rise_cnt <= rise_cnt + 1;

  always_comb begin
    mk   = (rise_cnt - rise_base) % 16;
    miso = 1'b0;
    if (mk >= 8) miso = resp_val[15 - mk];
  end

  task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] d, input bit hold);
    @(negedge iclk);
    cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    for (int w = 0; w < 500 && !cmd_ready; w++) @(negedge iclk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL accept: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge iclk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Called just after the acceptance edge; cycle n is sampled on the negedge after edge n
  task automatic watch(output logic [31:0] bits, output int rises, output int vcyc,
                       output logic [7:0] rd, output logic er, output int unstable,
                       output logic pulse2, output logic rdy_after);
    logic ps, pm;
    bits = '0; rises = 0; vcyc = -1; rd = '0; er = 1'b0; unstable = 0;
    pulse2 = 1'b1; rdy_after = 1'b0;
    rise_base = rise_cnt;
    ps = sclk; pm = mosi;
    for (int n = 1; n <= 600; n++) begin
      @(negedge iclk);
      if (sclk && !ps) begin bits = {bits[30:0], mosi}; rises++; end
      if (sclk && ps && (mosi !== pm)) unstable++;
      ps = sclk; pm = mosi;
      if (rsp_valid === 1'b1) begin
        vcyc = n; rd = rsp_rdata; er = rsp_err;
        @(negedge iclk);
        pulse2 = rsp_valid; rdy_after = cmd_ready;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge iclk);
      n_cmp++;
      if ({sclk, mosi, rsp_valid, busy} !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_outputs: {sclk,mosi,rsp_valid,busy}=%b required 0000", {sclk, mosi, rsp_valid, busy});
      end
    end
    rstn = 1'b1; cmd_valid = 1'b0;
    n_cmp++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_ready: {cmd_ready,busy}=%b required 10", {cmd_ready, busy});
    end
    n_cmp++;
    if ({rsp_rdata, rsp_err} !== 9'h000) begin
      n_bad++;
      $display("FAIL reset_rsp: rdata=%h err=%b required 00 0", rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_write();
    logic [31:0] b; int r, v, u; logic [7:0] d; logic e, p, ra;
    resp_val = 8'h81;
    issue(1'b0, 7'd3, 8'hA5, 1'b0);
    watch(b, r, v, d, e, u, p, ra);
    n_cmp++;
    if (b !== (VER ? 32'h03A5_8300 : 32'h0000_03A5)) begin
      n_bad++; $display("FAIL write_bits: got %h required %h", b, VER ? 32'h03A5_8300 : 32'h0000_03A5);
    end
    n_cmp++;
    if (r != (VER ? 32 : 16)) begin n_bad++; $display("FAIL write_rises: got %0d required %0d", r, VER ? 32 : 16); end
    n_cmp++;
    if (v != (VER ? T2 : T1)) begin n_bad++; $display("FAIL write_latency: got %0d required %0d", v, VER ? T2 : T1); end
    n_cmp++;
    if (d !== 8'h81) begin n_bad++; $display("FAIL write_rdata: got %h required 81", d); end
    n_cmp++;
    if (e !== VER) begin n_bad++; $display("FAIL write_err: got %b required %b", e, VER); end
    n_cmp++;
    if (u != 0) begin n_bad++; $display("FAIL write_mosi_stable: %0d changes while sclk high, required 0", u); end
    n_cmp++;
    if (p !== 1'b0) begin n_bad++; $display("FAIL write_pulse_width: rsp_valid=%b next cycle required 0", p); end
  endtask

  task automatic test_read();
    logic [31:0] b; int r, v, u; logic [7:0] d; logic e, p, ra;
    resp_val = 8'h3C;
    issue(1'b1, 7'd5, 8'hFF, 1'b0);
    watch(b, r, v, d, e, u, p, ra);
    n_cmp++;
    if (b !== 32'h0000_8500) begin n_bad++; $display("FAIL read_bits: got %h required 00008500", b); end
    n_cmp++;
    if (v != T1) begin n_bad++; $display("FAIL read_latency: got %0d required %0d", v, T1); end
    n_cmp++;
    if (d !== 8'h3C) begin n_bad++; $display("FAIL read_rdata: got %h required 3c", d); end
    n_cmp++;
    if (e !== 1'b0) begin n_bad++; $display("FAIL read_err: got %b required 0", e); end
    n_cmp++;
    if (ra !== 1'b1) begin n_bad++; $display("FAIL read_ready_after: got %b required 1", ra); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b; int r, v, u; logic [7:0] d; logic e, p, ra;
    resp_val = 8'h11;
    issue(1'b1, 7'd1, 8'h00, 1'b1);
    watch(b, r, v, d, e, u, p, ra);
    n_cmp++;
    if (r != 16 || v != T1) begin
      n_bad++; $display("FAIL busy_one_frame: rises=%0d cycle=%0d required 16 %0d", r, v, T1);
    end
    n_cmp++;
    if (ra !== 1'b1) begin n_bad++; $display("FAIL busy_ready_after_resp: got %b required 1", ra); end
    cmd_addr = 7'd6;
    resp_val = 8'hC3;
    @(posedge iclk);
    #1;
    cmd_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_second_accept: busy=%b required 1", busy); end
    watch(b, r, v, d, e, u, p, ra);
    n_cmp++;
    if (b !== 32'h0000_8600 || v != T1) begin
      n_bad++; $display("FAIL busy_second_frame: bits=%h cycle=%0d required 00008600 %0d", b, v, T1);
    end
    n_cmp++;
    if (d !== 8'hC3) begin n_bad++; $display("FAIL busy_second_rdata: got %h required c3", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] b; int r, v, u, nv; logic [7:0] d; logic e, p, ra;
    resp_val = 8'h00;
    issue(1'b0, 7'd7, 8'hFF, 1'b0);
    repeat (20) @(negedge iclk);
    n_cmp++;
    if (sclk !== 1'b1) begin n_bad++; $display("FAIL midreset_precheck: sclk=%b required 1", sclk); end
    rstn = 1'b0;
    @(negedge iclk);
    n_cmp++;
    if ({sclk, mosi, busy, rsp_valid} !== 4'b0000) begin
      n_bad++; $display("FAIL midreset_abort: {sclk,mosi,busy,rsp_valid}=%b required 0000", {sclk, mosi, busy, rsp_valid});
    end
    @(negedge iclk);
    rstn = 1'b1;
    nv = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge iclk);
      if (rsp_valid === 1'b1) nv++;
    end
    n_cmp++;
    if (nv != 0) begin n_bad++; $display("FAIL midreset_no_rsp: %0d pulses required 0", nv); end
    resp_val = 8'h96;
    issue(1'b1, 7'd4, 8'h00, 1'b0);
    watch(b, r, v, d, e, u, p, ra);
    n_cmp++;
    if (v != T1 || d !== 8'h96) begin
      n_bad++; $display("FAIL midreset_recover: cycle=%0d rdata=%h required %0d 96", v, d, T1);
    end
  endtask

  task automatic test_verify();
    logic [31:0] b; int r, v, u; logic [7:0] d; logic e, p, ra;
    resp_val = 8'h5B;
    issue(1'b0, 7'd2, 8'h5A, 1'b0);
    watch(b, r, v, d, e, u, p, ra);
    n_cmp++;
    if (b !== (VER ? 32'h025A_8200 : 32'h0000_025A)) begin
      n_bad++; $display("FAIL verify_bits: got %h required %h", b, VER ? 32'h025A_8200 : 32'h0000_025A);
    end
    n_cmp++;
    if (v != (VER ? T2 : T1)) begin n_bad++; $display("FAIL verify_latency: got %0d required %0d", v, VER ? T2 : T1); end
    n_cmp++;
    if (d !== 8'h5B || e !== VER) begin
      n_bad++; $display("FAIL verify_mismatch: rdata=%h err=%b required 5b %b", d, e, VER);
    end
    resp_val = 8'h5A;
    issue(1'b0, 7'd2, 8'h5A, 1'b0);
    watch(b, r, v, d, e, u, p, ra);
    n_cmp++;
    if (d !== 8'h5A || e !== 1'b0) begin
      n_bad++; $display("FAIL verify_match: rdata=%h err=%b required 5a 0", d, e);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_verify();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
